cam_insert_ctrl: RTL and testbench

Command-side initiator for the 32-entry CAM: accepts lookup/insert/delete/read requests over a valid/ready handshake and sequences the CAM's read, write and search strobes. It keeps the only record of which CAM entries are live, allocates free slots on insert, and returns one response per request. It sits between the packet-classification logic and the CAM, and owns every CAM strobe.

---
 rtl/cam_pkg.sv | 24 ++
 rtl/cam_free_finder.sv | 24 ++
 rtl/cam_insert_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_cam_insert_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared CAM definitions: operand widths, command opcodes and the
// controller FSM encoding, imported by the CAM and its controller.
package cam_pkg;

  localparam int CAM_DATA_WIDTH = 32;
  localparam int CAM_ADDR_WIDTH = 5;
  localparam int CAM_DEPTH      = 1 << CAM_ADDR_WIDTH;

  typedef enum logic [1:0] {
    OP_LOOKUP = 2'd0,
    OP_INSERT = 2'd1,
    OP_DELETE = 2'd2,
    OP_READ   = 2'd3
  } cam_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } cam_ctrl_state_e;

endpackage

// File: rtl/cam_free_finder.sv
// Lowest-zero priority encoder over the occupancy bitmap; picks the slot
// an INSERT miss will allocate.
module cam_free_finder #(
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic [DEPTH-1:0]      occ,
  output logic [ADDR_WIDTH-1:0] free_index,
  output logic                  any_free
);

  // Scan high to low so the last assignment wins with the lowest free slot.
  always_comb begin
    free_index = '0;
    any_free   = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!occ[i]) begin
        any_free   = 1'b1;
        free_index = ADDR_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/cam_insert_ctrl.sv
// Command-side CAM initiator: owns the live-entry bitmap, sequences CAM
// search/read/write strobes and returns one response per request.
module cam_insert_ctrl
  import cam_pkg::*;
#(
  parameter int DATA_WIDTH = CAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = CAM_ADDR_WIDTH,
  parameter int DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // Handshake: a transfer happens on a rising edge where valid and ready
  // are both 1; valid-side holds its payload stable until that edge.
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [1:0]            req_op_i,
  input  logic [DATA_WIDTH-1:0] req_data_i,
  input  logic [ADDR_WIDTH-1:0] req_index_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic                  rsp_hit_o,
  output logic                  rsp_full_o,
  output logic [ADDR_WIDTH-1:0] rsp_index_o,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic [ADDR_WIDTH:0]   occ_count_o,
  output logic                  cam_read_o,
  output logic [ADDR_WIDTH-1:0] cam_read_index_o,
  output logic                  cam_write_o,
  output logic [ADDR_WIDTH-1:0] cam_write_index_o,
  output logic [DATA_WIDTH-1:0] cam_write_data_o,
  output logic                  cam_search_o,
  output logic [DATA_WIDTH-1:0] cam_search_data_o,
  input  logic                  cam_read_valid_i,
  input  logic [DATA_WIDTH-1:0] cam_read_value_i,
  input  logic                  cam_search_valid_i,
  input  logic [ADDR_WIDTH-1:0] cam_search_index_i,
  output cam_ctrl_state_e       dbg_state_o
);

  cam_ctrl_state_e       state_q, state_d;
  cam_op_e               op_q, op_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [ADDR_WIDTH-1:0] index_q, index_d;
  logic [ADDR_WIDTH-1:0] wr_index_q, wr_index_d;
  logic [DEPTH-1:0]      occ_q, occ_d;
  logic [ADDR_WIDTH:0]   occ_count_q, occ_count_d;
  logic                  rsp_hit_q, rsp_hit_d;
  logic                  rsp_full_q, rsp_full_d;
  logic [ADDR_WIDTH-1:0] rsp_index_q, rsp_index_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic [ADDR_WIDTH-1:0] free_index;
  logic                  any_free;
  logic                  search_en, read_en, write_en;

  cam_free_finder #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_free_finder (
    .occ        (occ_q),
    .free_index (free_index),
    .any_free   (any_free)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    data_d      = data_q;
    index_d     = index_q;
    wr_index_d  = wr_index_q;
    occ_d       = occ_q;
    rsp_hit_d   = rsp_hit_q;
    rsp_full_d  = rsp_full_q;
    rsp_index_d = rsp_index_q;
    rsp_data_d  = rsp_data_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          op_d    = cam_op_e'(req_op_i);
          data_d  = req_data_i;
          index_d = req_index_i;
          if (cam_op_e'(req_op_i) == OP_DELETE) begin
            occ_d[req_index_i] = 1'b0;
            rsp_hit_d          = occ_q[req_index_i];
            rsp_full_d         = 1'b0;
            rsp_index_d        = req_index_i;
            rsp_data_d         = '0;
            state_d            = ST_RESP;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        rsp_full_d = 1'b0;
        rsp_data_d = '0;
        state_d    = ST_RESP;
        case (op_q)
          OP_INSERT: begin
            // A stale hit is rewritten in place so no stale lower-index
            // duplicate can shadow the live key on a later search.
            if (cam_search_valid_i && occ_q[cam_search_index_i]) begin
              rsp_hit_d   = 1'b1;
              rsp_index_d = cam_search_index_i;
            end else if (cam_search_valid_i) begin
              wr_index_d = cam_search_index_i;
              state_d    = ST_WRITE;
            end else if (any_free) begin
              wr_index_d = free_index;
              state_d    = ST_WRITE;
            end else begin
              rsp_hit_d   = 1'b0;
              rsp_full_d  = 1'b1;
              rsp_index_d = '0;
            end
          end
          OP_READ: begin
            rsp_hit_d   = occ_q[index_q];
            rsp_index_d = index_q;
            rsp_data_d  = cam_read_value_i;
          end
          default: begin
            rsp_hit_d   = cam_search_valid_i && occ_q[cam_search_index_i];
            rsp_index_d = (cam_search_valid_i && occ_q[cam_search_index_i]) ?
                          cam_search_index_i : '0;
          end
        endcase
      end
      ST_WRITE: begin
        occ_d[wr_index_q] = 1'b1;
        rsp_hit_d         = 1'b0;
        rsp_full_d        = 1'b0;
        rsp_index_d       = wr_index_q;
        rsp_data_d        = '0;
        state_d           = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    occ_count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_count_d = occ_count_d + (ADDR_WIDTH + 1)'(occ_q[i]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_LOOKUP;
      data_q      <= '0;
      index_q     <= '0;
      wr_index_q  <= '0;
      occ_q       <= '0;
      occ_count_q <= '0;
      rsp_hit_q   <= 1'b0;
      rsp_full_q  <= 1'b0;
      rsp_index_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      data_q      <= data_d;
      index_q     <= index_d;
      wr_index_q  <= wr_index_d;
      occ_q       <= occ_d;
      occ_count_q <= occ_count_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_full_q  <= rsp_full_d;
      rsp_index_q <= rsp_index_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Gating with rst_i keeps strobes and handshakes quiet in the reset cycle.
  assign search_en = rst_i && (state_q == ST_ISSUE) && (op_q != OP_READ);
  assign read_en   = rst_i && (state_q == ST_ISSUE) && (op_q == OP_READ);
  assign write_en  = rst_i && (state_q == ST_WRITE);

  assign req_ready_o       = rst_i && (state_q == ST_IDLE);
  assign rsp_valid_o       = rst_i && (state_q == ST_RESP);
  assign rsp_hit_o         = rsp_hit_q;
  assign rsp_full_o        = rsp_full_q;
  assign rsp_index_o       = rsp_index_q;
  assign rsp_data_o        = rsp_data_q;
  assign occ_count_o       = occ_count_q;
  assign cam_search_o      = search_en;
  assign cam_search_data_o = search_en ? data_q : '0;
  assign cam_read_o        = read_en;
  assign cam_read_index_o  = read_en ? index_q : '0;
  assign cam_write_o       = write_en;
  assign cam_write_index_o = write_en ? wr_index_q : '0;
  assign cam_write_data_o  = write_en ? data_q : '0;
  assign dbg_state_o       = state_q;

  logic unused_read_valid;
  assign unused_read_valid = cam_read_valid_i;

endmodule

// File: tb/tb_cam_insert_ctrl.sv
// Directed bench for cam_insert_ctrl with a behavioural 32-entry CAM that
// answers one cycle after each strobe with the lowest matching index.
module tb_cam_insert_ctrl;
  import cam_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'd0;
  logic [31:0] req_data = '0;
  logic [4:0]  req_index = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic        rsp_hit, rsp_full;
  logic [4:0]  rsp_index;
  logic [31:0] rsp_data;
  logic [5:0]  occ_count;
  logic        cam_read, cam_write, cam_search;
  logic [4:0]  cam_read_index, cam_write_index;
  logic [31:0] cam_write_data, cam_search_data;
  logic        cam_read_valid = 1'b0;
  logic [31:0] cam_read_value = '0;
  logic        cam_search_valid = 1'b0;
  logic [4:0]  cam_search_index = '0;
  cam_ctrl_state_e dbg_state;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cam_insert_ctrl dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .req_valid_i        (req_valid),
    .req_ready_o        (req_ready),
    .req_op_i           (req_op),
    .req_data_i         (req_data),
    .req_index_i        (req_index),
    .rsp_valid_o        (rsp_valid),
    .rsp_ready_i        (rsp_ready),
    .rsp_hit_o          (rsp_hit),
    .rsp_full_o         (rsp_full),
    .rsp_index_o        (rsp_index),
    .rsp_data_o         (rsp_data),
    .occ_count_o        (occ_count),
    .cam_read_o         (cam_read),
    .cam_read_index_o   (cam_read_index),
    .cam_write_o        (cam_write),
    .cam_write_index_o  (cam_write_index),
    .cam_write_data_o   (cam_write_data),
    .cam_search_o       (cam_search),
    .cam_search_data_o  (cam_search_data),
    .cam_read_valid_i   (cam_read_valid),
    .cam_read_value_i   (cam_read_value),
    .cam_search_valid_i (cam_search_valid),
    .cam_search_index_i (cam_search_index),
    .dbg_state_o        (dbg_state)
  );

  // CAM model: no invalidate, so written entries persist across resets.
  logic [31:0] cam_mem [32];
  logic [31:0] cam_written = '0;
  logic        srch_hit;
  logic [4:0]  srch_idx;

  always @(posedge clk) begin
    srch_hit = 1'b0;
    srch_idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (cam_written[i] && cam_mem[i] == cam_search_data) begin
        srch_hit = 1'b1;
        srch_idx = 5'(i);
      end
    end
    cam_search_valid <= cam_search && srch_hit;
    cam_search_index <= (cam_search && srch_hit) ? srch_idx : 5'd0;
    cam_read_valid   <= cam_read;
    cam_read_value   <= cam_read ? cam_mem[cam_read_index] : 32'd0;
    if (cam_write) begin
      cam_mem[cam_write_index]     <= cam_write_data;
      cam_written[cam_write_index] <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Results of the last send()
  int          r_lat, r_slat, r_wlat, r_wcnt;
  logic [4:0]  r_widx;
  logic        r_acc, r_hit, r_full;
  logic [4:0]  r_index;
  logic [31:0] r_data;

  task automatic send(input logic [1:0] op, input logic [31:0] d, input logic [4:0] idx);
    r_lat = 0; r_slat = 0; r_wlat = 0; r_wcnt = 0; r_widx = '0;
    @(negedge clk);
    r_acc     = req_ready;
    req_valid = 1'b1;
    req_op    = op;
    req_data  = d;
    req_index = idx;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (cam_search) r_slat = k;
      if (cam_write) begin
        r_wlat = k;
        r_wcnt++;
        r_widx = cam_write_index;
      end
      if (rsp_valid) begin
        r_lat = k;
        break;
      end
      @(posedge clk); #1;
    end
    r_hit   = rsp_hit;
    r_full  = rsp_full;
    r_index = rsp_index;
    r_data  = rsp_data;
    @(posedge clk); #1;
  endtask

  task automatic exp_rsp(input string tag, input int lat, input logic hit,
                         input logic full, input logic [4:0] index, input int wcnt);
    chk({tag, ".accept"}, 32'(r_acc), 32'd1);
    chk({tag, ".lat"},    32'(r_lat), 32'(lat));
    chk({tag, ".hit"},    32'(r_hit), 32'(hit));
    chk({tag, ".full"},   32'(r_full), 32'(full));
    chk({tag, ".index"},  32'(r_index), 32'(index));
    chk({tag, ".writes"}, 32'(r_wcnt), 32'(wcnt));
  endtask

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst.req_ready", 32'(req_ready), 32'd0);
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst.occ_count", 32'(occ_count), 32'd0);
    chk("rst.strobes",   32'({cam_search, cam_read, cam_write}), 32'd0);
    chk("rst.state",     32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rel.req_ready", 32'(req_ready), 32'd1);

    // First insert: search at 1, write idx 0 at 3, response at 4
    send(OP_INSERT, 32'hDEADBEEF, 5'd0);
    exp_rsp("ins0", 4, 1'b0, 1'b0, 5'd0, 1);
    chk("ins0.search_cyc", 32'(r_slat), 32'd1);
    chk("ins0.write_cyc",  32'(r_wlat), 32'd3);
    chk("ins0.write_idx",  32'(r_widx), 32'd0);
    chk("ins0.occ_count",  32'(occ_count), 32'd1);

    send(OP_LOOKUP, 32'hDEADBEEF, 5'd0);
    exp_rsp("lk_hit", 3, 1'b1, 1'b0, 5'd0, 0);
    send(OP_LOOKUP, 32'h12345678, 5'd0);
    exp_rsp("lk_miss", 3, 1'b0, 1'b0, 5'd0, 0);

    send(OP_INSERT, 32'hDEADBEEF, 5'd0);
    exp_rsp("ins_dup", 3, 1'b1, 1'b0, 5'd0, 0);
    chk("ins_dup.occ_count", 32'(occ_count), 32'd1);

    send(OP_READ, 32'd0, 5'd0);
    exp_rsp("rd0", 3, 1'b1, 1'b0, 5'd0, 0);
    chk("rd0.data", r_data, 32'hDEADBEEF);

    // Fill remaining 31 slots in ascending order
    for (int i = 1; i < 32; i++) begin
      send(OP_INSERT, 32'h1000 + 32'(i), 5'd0);
      chk("fill.index", 32'(r_index), 32'(i));
      chk("fill.writes", 32'(r_wcnt), 32'd1);
    end
    chk("fill.occ_count", 32'(occ_count), 32'd32);

    send(OP_INSERT, 32'hABCDEF01, 5'd0);
    exp_rsp("ins_full", 3, 1'b0, 1'b1, 5'd0, 0);
    chk("ins_full.occ_count", 32'(occ_count), 32'd32);

    send(OP_DELETE, 32'd0, 5'd0);
    exp_rsp("del0", 1, 1'b1, 1'b0, 5'd0, 0);
    chk("del0.occ_count", 32'(occ_count), 32'd31);
    send(OP_DELETE, 32'd0, 5'd0);
    exp_rsp("del0_again", 1, 1'b0, 1'b0, 5'd0, 0);
    chk("del0_again.occ_count", 32'(occ_count), 32'd31);

    send(OP_LOOKUP, 32'hDEADBEEF, 5'd0);
    chk("lk_stale.hit", 32'(r_hit), 32'd0);
    send(OP_READ, 32'd0, 5'd0);
    chk("rd_stale.hit", 32'(r_hit), 32'd0);
    chk("rd_stale.data", r_data, 32'hDEADBEEF);

    send(OP_INSERT, 32'hDEADBEEF, 5'd0);
    exp_rsp("ins_stale", 4, 1'b0, 1'b0, 5'd0, 1);
    chk("ins_stale.write_idx", 32'(r_widx), 32'd0);
    chk("ins_stale.occ_count", 32'(occ_count), 32'd32);

    send(OP_DELETE, 32'd0, 5'd5);
    exp_rsp("del5", 1, 1'b1, 1'b0, 5'd5, 0);
    send(OP_INSERT, 32'h00000077, 5'd0);
    exp_rsp("ins_alloc5", 4, 1'b0, 1'b0, 5'd5, 1);
    chk("ins_alloc5.write_idx", 32'(r_widx), 32'd5);

    // Response back-pressure: fields hold, no new request accepted
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = OP_LOOKUP;
    req_data  = 32'h00001003;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("hold.valid0", 32'(rsp_valid), 32'd1);
    chk("hold.hit0",   32'(rsp_hit), 32'd1);
    chk("hold.index0", 32'(rsp_index), 32'd3);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("hold.valid", 32'(rsp_valid), 32'd1);
      chk("hold.hit",   32'(rsp_hit), 32'd1);
      chk("hold.index", 32'(rsp_index), 32'd3);
      chk("hold.ready", 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold.release_valid", 32'(rsp_valid), 32'd0);
    chk("hold.release_ready", 32'(req_ready), 32'd1);

    // Reset while waiting on the CAM result
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = OP_INSERT;
    req_data  = 32'h00000999;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid.state", 32'(dbg_state), 32'(ST_WAIT));
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid.req_ready", 32'(req_ready), 32'd0);
    chk("mid.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid.occ_count", 32'(occ_count), 32'd0);
    chk("mid.strobes",   32'({cam_search, cam_read, cam_write}), 32'd0);
    chk("mid.rsp_fields", 32'({rsp_hit, rsp_full, rsp_index}), 32'd0);
    chk("mid.state_idle", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid.rel_ready", 32'(req_ready), 32'd1);
    send(OP_LOOKUP, 32'hDEADBEEF, 5'd0);
    exp_rsp("post_rst_lk", 3, 1'b0, 1'b0, 5'd0, 0);
    chk("post_rst.occ_count", 32'(occ_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
